// File: rtl/result_fifo.sv
// Result word FIFO between the logic controller and the host pipe-out reader.
// Define RESULT_FIFO_OVF_CNT_EN to add the saturating ovf_cnt dropped-word counter.
module result_fifo #(
  parameter int ADDR_W     = 10,
  parameter int BLOCK_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              din_en,
  input  logic [15:0]       din,
  input  logic              rd_en,
  output logic [15:0]       dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              blk_rdy,
  output logic              ovf,
`ifdef RESULT_FIFO_OVF_CNT_EN
  output logic [15:0]       ovf_cnt,
`endif
  output logic              unf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] BLK_CNT  = (ADDR_W+1)'(BLOCK_SIZE);

  logic [15:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              blk_rdy_q, blk_rdy_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_acc, wr_acc, drop;

  // A full FIFO still takes a write when a read frees a slot the same cycle.
  assign rd_acc = rd_en & ~empty_q;
  assign wr_acc = din_en & (~full_q | rd_acc);
  assign drop   = din_en & ~wr_acc;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
        dout_d       = mem[rd_ptr_q];
        dout_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
      if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
      if (drop) ovf_d = 1'b1;
      if (rd_en && empty_q) unf_d = 1'b1;
    end
    empty_d   = (count_d == '0);
    full_d    = (count_d == FULL_CNT);
    blk_rdy_d = (count_d >= BLK_CNT);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      blk_rdy_q    <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      blk_rdy_q    <= blk_rdy_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

`ifdef RESULT_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr) ovf_cnt_d = '0;
    else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign blk_rdy    = blk_rdy_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;

endmodule

// File: doc/result_fifo.md
# result_fifo

Buffers the 16-bit result words produced by the logic controller (`data_out` / `data_out_en`: ADC samples and 3-word timestamps) and hands them to the host pipe-out reader. Sits directly downstream of the logic controller and upstream of the host interface. It decouples the measurement clock-domain timing from host reads, exposes a block-ready flag for block-throttled transfers, and latches overflow and underflow conditions.

## Interface
Parameters:
- `ADDR_W`, 10: address width; depth = 2^ADDR_W words.
- `BLOCK_SIZE`, 256: word threshold for `blk_rdy`; legal range 1..2^ADDR_W.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous flush, driven from the memory-block clear.
- `din_en`  in  1  write strobe; connects to the controller's `data_out_en`.
- `din`  in  16  write data; connects to the controller's `data_out`.
- `rd_en`  in  1  read strobe from the host pipe.
- `dout`  out  16  read data, registered.
- `dout_valid`  out  1  one-cycle pulse; `dout` is valid.
- `count`  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == 2^ADDR_W`.
- `blk_rdy`  out  1  `count >= BLOCK_SIZE`.
- `ovf`  out  1  sticky flag: a write was dropped.
- `unf`  out  1  sticky flag: a read was issued while empty.
- `ovf_cnt`  out  16  dropped-word count. Present only with `RESULT_FIFO_OVF_CNT_EN`.

## Operation
- Storage: dual-port RAM of 2^ADDR_W x 16. Write and read pointers are ADDR_W bits wide and wrap modulo the depth. `count` is a separate register.
- Write accept: `din_en & (!full | rd_acc)`. A full FIFO accepts a write in the same cycle as an accepted read.
- Read accept: `rd_acc = rd_en & !empty`. A simultaneous write does not make an empty FIFO readable.
- `count` next value: +1 on write-only, -1 on read-only, unchanged when both or neither occur.
- Dropped write (`din_en & !write_accept`): set `ovf`. FIFO contents and `count` are unchanged.
- Rejected read (`rd_en & empty`): set `unf`. `dout` holds its value and `dout_valid` stays 0.
- Flags `empty`, `full` and `blk_rdy` are registered from the next `count` value, so they agree with `count` on every cycle.
- `clr`: zeroes both pointers, `count`, `ovf`, `unf` and `ovf_cnt`, and forces `dout_valid` to 0. `clr` has priority over `din_en` and `rd_en` in the same cycle; both are ignored. RAM contents are not cleared.
- Reset values (`rst`): `dout`=0, `dout_valid`=0, `count`=0, `empty`=1, `full`=0, `blk_rdy`=0, `ovf`=0, `unf`=0, `ovf_cnt`=0, pointers=0. Reset acts asynchronously, including mid-transfer, and any pending word is lost.

## Timing
- Write latency: a word accepted at edge N is readable through `rd_en` sampled at edge N+1, i.e. `empty` falls after edge N.
- Read latency: `rd_en` accepted at edge N gives `dout` and `dout_valid`=1 after edge N, for one cycle.
- Back-to-back reads: one word per cycle, with `dout_valid` high continuously.
- Timestamp bursts: 3 consecutive `din_en` cycles are accepted with no bubbles.
- Flag update latency: `ovf` and `unf` rise one edge after the offending strobe. They are cleared only by `clr` or `rst`.

## Configuration
- `RESULT_FIFO_OVF_CNT_EN` defined:
  - `ovf_cnt` port exists.
  - It increments on each dropped write and saturates at 16'hFFFF.
  - It is cleared by `clr` and `rst`.
- `RESULT_FIFO_OVF_CNT_EN` undefined:
  - Port and counter are absent.
  - Only the sticky `ovf` flag reports loss.

## Test plan
- Reset then write 3 words 0x0001, 0x0002, 0x0003 on consecutive cycles -> `count`=3, `empty`=0. Then 3 reads -> `dout` is 0x0001, 0x0002, 0x0003 on consecutive cycles with `dout_valid`=1, and `empty`=1 afterwards.
- ADDR_W=4, BLOCK_SIZE=8: write 8 words -> `blk_rdy` rises after the 8th write edge. Read 1 word -> `blk_rdy`=0.
- ADDR_W=4: write 17 words -> `full`=1, `count`=16, `ovf`=1; `ovf_cnt`=1 when the macro is enabled. Read all 16 -> the first 16 values return in order.
- When full, assert `din_en`=1 and `rd_en`=1 in the same cycle with `din`=0xBEEF -> `count` stays 16, `ovf` stays 0, and 0xBEEF is the last word read out.
- Assert `rd_en` while empty -> `unf`=1, `dout_valid`=0. Write 0x1234 with `rd_en` in the same cycle -> read rejected, `count`=1.
- Write 5 words, assert `clr` together with `din_en` and `rd_en` -> `count`=0, `empty`=1, no `dout_valid`, flags cleared. Assert `rst` mid-burst -> all outputs return to their reset values immediately.
